// File: rtl/ep_phy_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ep_phy_seq_pkg                                                         |
// | Shared state codes, counter widths and helpers for ep_phy_link_seq.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package ep_phy_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PHY_RST   = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_WAIT_SYNC = 3'd3,
        S_LINK_UP   = 3'd4,
        S_BACKOFF   = 3'd5
    } seq_state_t;

    localparam int c_restart_cnt_w = 8;
    localparam int c_err_cnt_w     = 16;

    // Width able to hold the largest limit value itself.
    function automatic int cnt_width(input int max_limit);
        return (max_limit < 2) ? 1 : $clog2(max_limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ep_phy_seq_err_window.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ep_phy_seq_err_window                                                  |
// | Windowed 8b/10b error counter with threshold detect for the sequencer. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module ep_phy_seq_err_window
    import ep_phy_seq_pkg::*;
#(
    parameter int g_err_window    = 4096,
    parameter int g_err_threshold = 16
) (
    input  logic                   clk_sys_i,
    input  logic                   rst_i,
    input  logic                   active,
    input  logic                   err_pulse,
    output logic [c_err_cnt_w-1:0] err_cnt,
    output logic                   thresh_hit
);

    localparam int c_win_w = (g_err_window > 1) ? $clog2(g_err_window) : 1;
    localparam logic [c_win_w-1:0]     c_win_last = c_win_w'(g_err_window - 1);
    localparam logic [c_err_cnt_w-1:0] c_thresh   = c_err_cnt_w'(g_err_threshold);

    logic [c_win_w-1:0]     win;
    logic                   wrap;
    logic [c_err_cnt_w-1:0] cnt_next;

    assign wrap = (win == c_win_last);

    // A pulse on the wrap cycle belongs to the window that starts next.
    always_comb begin
        cnt_next = err_cnt;
        if (wrap) begin
            cnt_next = c_err_cnt_w'(err_pulse);
        end else if (err_pulse && (err_cnt != '1)) begin
            cnt_next = err_cnt + 1'b1;
        end
    end

    assign thresh_hit = active && (cnt_next >= c_thresh);

    always_ff @(posedge clk_sys_i) begin
        if (rst_i || !active) begin
            win     <= '0;
            err_cnt <= '0;
        end else begin
            win     <= wrap ? '0 : win + 1'b1;
            err_cnt <= cnt_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ep_phy_link_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ep_phy_link_seq                                                        |
// | PHY bring-up / supervision sequencer; EP_PHY_SEQ_ERR_MON_EN adds the   |
// | windowed 8b/10b error monitor.                                         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module ep_phy_link_seq
    import ep_phy_seq_pkg::*;
#(
    parameter int g_rst_cycles     = 256,
    parameter int g_lock_timeout   = 65535,
    parameter int g_sync_timeout   = 1000000,
    parameter int g_backoff_cycles = 1024,
    parameter int g_err_window     = 4096,
    parameter int g_err_threshold  = 16
) (
    input  logic                       clk_sys_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic                       loopen_req_i,
    input  logic                       pll_locked_i,
    input  logic                       rx_synced_i,
    input  logic                       rx_enc_err_i,
    output logic                       phy_rst_o,
    output logic                       phy_enable_o,
    output logic                       phy_syncen_o,
    output logic                       phy_loopen_o,
    output logic                       link_up_o,
    output logic [2:0]                 state_o,
    output logic [c_restart_cnt_w-1:0] restart_cnt_o,
    output logic [c_err_cnt_w-1:0]     err_cnt_o
);

    localparam int c_max_ab  = (g_rst_cycles > g_lock_timeout) ? g_rst_cycles : g_lock_timeout;
    localparam int c_max_cd  = (g_sync_timeout > g_backoff_cycles) ? g_sync_timeout : g_backoff_cycles;
    localparam int c_max_lim = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
    localparam int c_cnt_w   = cnt_width(c_max_lim);

    localparam logic [c_cnt_w-1:0] c_rst_lim  = c_cnt_w'(g_rst_cycles);
    localparam logic [c_cnt_w-1:0] c_lock_lim = c_cnt_w'(g_lock_timeout);
    localparam logic [c_cnt_w-1:0] c_sync_lim = c_cnt_w'(g_sync_timeout);
    localparam logic [c_cnt_w-1:0] c_bo_lim   = c_cnt_w'(g_backoff_cycles);

    seq_state_t         state;
    seq_state_t         state_next;
    // Holds the number of cycles spent in the current state, including this one.
    logic [c_cnt_w-1:0] dur_cnt;
    logic               err_hit;
    logic               link_active;
    logic               enter_backoff;
    logic               rst_d;
    logic               enable_d;
    logic               syncen_d;
    logic               loopen_d;
    logic               link_d;

    assign link_active = (state == S_LINK_UP);

    always_comb begin
        state_next = state;
        if (!enable_i) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:      state_next = S_PHY_RST;
                S_PHY_RST:   if (dur_cnt == c_rst_lim) state_next = S_WAIT_LOCK;
                S_WAIT_LOCK: begin
                    if (pll_locked_i)               state_next = S_WAIT_SYNC;
                    else if (dur_cnt == c_lock_lim) state_next = S_BACKOFF;
                end
                S_WAIT_SYNC: begin
                    if (!pll_locked_i)              state_next = S_BACKOFF;
                    else if (rx_synced_i)           state_next = S_LINK_UP;
                    else if (dur_cnt == c_sync_lim) state_next = S_BACKOFF;
                end
                S_LINK_UP:   if (!rx_synced_i || !pll_locked_i || err_hit) state_next = S_BACKOFF;
                S_BACKOFF:   if (dur_cnt == c_bo_lim) state_next = S_PHY_RST;
                default:     state_next = S_IDLE;
            endcase
        end

        // Controls are decoded from the next state so they register alongside it.
        enter_backoff = (state_next == S_BACKOFF) && (state != S_BACKOFF);
        rst_d    = (state_next == S_IDLE) || (state_next == S_PHY_RST) || (state_next == S_BACKOFF);
        enable_d = (state_next == S_WAIT_LOCK) || (state_next == S_WAIT_SYNC) || (state_next == S_LINK_UP);
        syncen_d = (state_next == S_WAIT_SYNC) || (state_next == S_LINK_UP);
        link_d   = (state_next == S_LINK_UP);
        loopen_d = link_d && loopen_req_i;
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            phy_rst_o     <= 1'b1;
            phy_enable_o  <= 1'b0;
            phy_syncen_o  <= 1'b0;
            phy_loopen_o  <= 1'b0;
            link_up_o     <= 1'b0;
            restart_cnt_o <= '0;
        end else begin
            state         <= state_next;
            phy_rst_o     <= rst_d;
            phy_enable_o  <= enable_d;
            phy_syncen_o  <= syncen_d;
            phy_loopen_o  <= loopen_d;
            link_up_o     <= link_d;
            if (enter_backoff && (restart_cnt_o != '1)) begin
                restart_cnt_o <= restart_cnt_o + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i || (state_next != state)) begin
            dur_cnt <= c_cnt_w'(1);
        end else if (dur_cnt != '1) begin
            dur_cnt <= dur_cnt + 1'b1;
        end
    end

    assign state_o = state;

`ifdef EP_PHY_SEQ_ERR_MON_EN
    ep_phy_seq_err_window #(
        .g_err_window    (g_err_window),
        .g_err_threshold (g_err_threshold)
    ) u_err_window (
        .clk_sys_i  (clk_sys_i),
        .rst_i      (rst_i),
        .active     (link_active),
        .err_pulse  (rx_enc_err_i),
        .err_cnt    (err_cnt_o),
        .thresh_hit (err_hit)
    );
`else
    logic unused_err;
    assign unused_err = rx_enc_err_i ^ link_active ^ (g_err_window == 0) ^ (g_err_threshold == 0);
    assign err_hit    = 1'b0;
    assign err_cnt_o  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ep_phy_link_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_ep_phy_link_seq                                                     |
// | Vector table, corner sequences and random run against a cycle model.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_ep_phy_link_seq;

    localparam int RST_C = 8, LOCK_TO = 20, SYNC_TO = 30, BO_C = 5, ERR_WIN = 64, ERR_THR = 4;
`ifdef EP_PHY_SEQ_ERR_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, en, lreq, lock, sync, err;
    logic phy_rst, phy_en, phy_syncen, phy_loop, link;
    logic [2:0]  st;
    logic [7:0]  rc;
    logic [15:0] ec;
    logic [31:0] act_vec;
    logic [31:0] exp_vec;

    int checks = 0;
    int errors = 0;
    int m_state, m_time, m_rc, m_err, m_win;

    always #5 clk = ~clk;

    ep_phy_link_seq #(
        .g_rst_cycles(RST_C), .g_lock_timeout(LOCK_TO), .g_sync_timeout(SYNC_TO),
        .g_backoff_cycles(BO_C), .g_err_window(ERR_WIN), .g_err_threshold(ERR_THR)
    ) dut (
        .clk_sys_i(clk), .rst_i(rst), .enable_i(en), .loopen_req_i(lreq),
        .pll_locked_i(lock), .rx_synced_i(sync), .rx_enc_err_i(err),
        .phy_rst_o(phy_rst), .phy_enable_o(phy_en), .phy_syncen_o(phy_syncen),
        .phy_loopen_o(phy_loop), .link_up_o(link), .state_o(st),
        .restart_cnt_o(rc), .err_cnt_o(ec)
    );

    assign act_vec = {st, phy_rst, phy_en, phy_syncen, phy_loop, link, rc, ec};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] mk_exp(input int s, input bit lp, input int r, input int e);
        return {3'(s), (s == 0 || s == 1 || s == 5), (s >= 2 && s <= 4), (s == 3 || s == 4),
                lp, (s == 4), 8'(r), 16'(e)};
    endfunction

    // One-cycle reference: state rules, restart accounting and per-window error tally.
    task automatic model_step();
        int ns, w, e_out;
        bit hit;
        if (rst) begin
            m_state = 0; m_time = 1; m_rc = 0; m_err = 0; m_win = 0;
            exp_vec = mk_exp(0, 1'b0, 0, 0);
            return;
        end
        hit = 1'b0;
        e_out = 0;
        if (m_state == 4 && MON) begin
            w = m_time / ERR_WIN;
            if (w != m_win) begin
                m_win = w;
                m_err = 0;
            end
            if (err) m_err = (m_err >= 65535) ? 65535 : m_err + 1;
            e_out = m_err;
            hit = (m_err >= ERR_THR);
        end
        ns = m_state;
        if (!en) ns = 0;
        else begin
            case (m_state)
                0: ns = 1;
                1: if (m_time == RST_C) ns = 2;
                2: if (lock) ns = 3; else if (m_time == LOCK_TO) ns = 5;
                3: if (!lock) ns = 5; else if (sync) ns = 4; else if (m_time == SYNC_TO) ns = 5;
                4: if (!sync || !lock || hit) ns = 5;
                5: if (m_time == BO_C) ns = 1;
                default: ns = 0;
            endcase
        end
        if (ns == 5 && m_state != 5 && m_rc < 255) m_rc++;
        if (ns == 4 && m_state != 4) begin
            m_err = 0;
            m_win = 0;
        end
        m_time  = (ns == m_state) ? m_time + 1 : 1;
        m_state = ns;
        exp_vec = mk_exp(ns, (ns == 4) && lreq, m_rc, e_out);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("cycle", act_vec, exp_vec);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic bring_up();
        en = 1'b1; lock = 1'b1; sync = 1'b1; err = 1'b0;
        repeat (11) tick();
    endtask

    typedef struct {
        bit en, lock, sync, lreq;
        int ncyc;
        int st;
        bit prst, link, loop;
        int rc;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; lreq = 1'b0; lock = 1'b0; sync = 1'b0; err = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_vals", act_vec, 32'h1000_0000);

        // Bring-up, loopback gating, lock loss, lock timeout, disable in BACKOFF.
        tbl[0]  = '{0, 1, 1, 0,  3, 0, 1, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 1,  1, 1, 1, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 1,  7, 1, 1, 0, 0, 0};
        tbl[3]  = '{1, 1, 1, 1,  1, 2, 0, 0, 0, 0};
        tbl[4]  = '{1, 1, 1, 1,  1, 3, 0, 0, 0, 0};
        tbl[5]  = '{1, 1, 1, 1,  1, 4, 0, 1, 1, 0};
        tbl[6]  = '{1, 1, 1, 0,  1, 4, 0, 1, 0, 0};
        tbl[7]  = '{1, 0, 1, 0,  1, 5, 1, 0, 0, 1};
        tbl[8]  = '{1, 0, 1, 0,  4, 5, 1, 0, 0, 1};
        tbl[9]  = '{1, 0, 1, 0,  1, 1, 1, 0, 0, 1};
        tbl[10] = '{1, 0, 1, 0,  8, 2, 0, 0, 0, 1};
        tbl[11] = '{1, 0, 1, 0, 19, 2, 0, 0, 0, 1};
        tbl[12] = '{1, 0, 1, 0,  1, 5, 1, 0, 0, 2};
        tbl[13] = '{1, 0, 1, 0,  2, 5, 1, 0, 0, 2};
        tbl[14] = '{0, 0, 1, 0,  1, 0, 1, 0, 0, 2};
        for (int i = 0; i < 15; i++) begin
            en = tbl[i].en; lock = tbl[i].lock; sync = tbl[i].sync; lreq = tbl[i].lreq; err = 1'b0;
            for (int n = 0; n < tbl[i].ncyc; n++) tick();
            check($sformatf("vec%0d", i), {18'd0, st, phy_rst, link, phy_loop, rc},
                  {18'd0, 3'(tbl[i].st), tbl[i].prst, tbl[i].link, tbl[i].loop, 8'(tbl[i].rc)});
        end

        // Sync loss coinciding with the threshold error: one restart only.
        bring_up();
        check("link_up", {29'd0, st}, 32'd4);
        err = 1'b1;
        repeat (3) tick();
        sync = 1'b0;
        tick();
        check("sync_loss", {20'd0, st, link, rc}, {20'd0, 3'd5, 1'b0, 8'd3});
        err = 1'b0;
        tick();
        check("single_inc", {24'd0, rc}, 32'd3);
        en = 1'b0;
        tick();

`ifdef EP_PHY_SEQ_ERR_MON_EN
        bring_up();
        for (int k = 0; k < 64; k++) begin
            err = (k == 10 || k == 11 || k == 12 || k == 63);
            tick();
            if (k == 62) check("err_pre_wrap", {16'd0, ec}, 32'd3);
        end
        check("err_wrap", {13'd0, st, rc, ec}, {13'd0, 3'd4, 8'd3, 16'd1});
        err = 1'b0;
        for (int k = 64; k < 128; k++) tick();
        for (int k = 128; k < 132; k++) begin
            err = 1'b1;
            tick();
        end
        check("err_thresh", {21'd0, st, rc}, {21'd0, 3'd5, 8'd4});
        err = 1'b0;
        en = 1'b0;
        tick();
`endif

        // Loopback gated until LINK_UP, then reset from WAIT_SYNC.
        do_reset();
        en = 1'b1; lock = 1'b1; sync = 1'b0; lreq = 1'b1;
        repeat (13) tick();
        check("loop_gated", {28'd0, st, phy_loop}, {28'd0, 3'd3, 1'b0});
        do_reset();
        check("rst_in_sync", act_vec, 32'h1000_0000);
        sync = 1'b1;
        repeat (11) tick();
        check("loop_on", {28'd0, st, phy_loop}, {28'd0, 3'd4, 1'b1});

        // Restart counter saturation, then disable mid-BACKOFF.
        do_reset();
        en = 1'b1; lock = 1'b0; sync = 1'b0; lreq = 1'b0;
        for (int i = 0; i < 300 * (RST_C + LOCK_TO + BO_C) + 10; i++) tick();
        check("rc_sat", {24'd0, rc}, 32'd255);
        for (int i = 0; i < 40 && m_state != 5; i++) tick();
        tick();
        tick();
        en = 1'b0;
        tick();
        check("disable_bo", {21'd0, st, rc}, {21'd0, 3'd0, 8'd255});

        // Randomised run; long stable-link segments let the error monitor trip.
        do_reset();
        for (int seg = 0; seg < 20; seg++) begin
            bit calm;
            calm = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < 200; i++) begin
                rst  = ($urandom_range(0, 999) == 0);
                en   = ($urandom_range(0, 149) != 0);
                lock = calm ? ($urandom_range(0, 255) != 0) : ($urandom_range(0, 15) != 0);
                sync = calm ? ($urandom_range(0, 127) != 0) : ($urandom_range(0, 3) != 0);
                err  = ($urandom_range(0, 9) == 0);
                lreq = 1'($urandom);
                tick();
            end
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
